// File: rtl/ber_error_counter.sv
// ber_error_counter: receive-side bit error ratio measurement stage.
// Compares each received byte against the regenerated reference byte. Over a
// programmable window of bytes it accumulates the mismatched-bit count and the
// total number of bits checked.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start          one-cycle request to begin a window (accepted in IDLE/DONE)
//   window_len     bytes to check, latched on an accepted start
//   rx_valid       qualifier for rx_data/ref_data
//   rx_data        received (possibly corrupted) byte
//   ref_data       expected byte, aligned with rx_data
//   busy           window in progress, including the flush cycle
//   done           one-cycle pulse when the results are final
//   err_count      accumulated mismatched bits (saturating)
//   bit_count      accumulated checked bits (saturating)
//   err_seen       sticky: a mismatch was accumulated in this window
module ber_error_counter #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  window_len,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [DATA_W-1:0] ref_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  bit_count,
    output logic              err_seen
);

    localparam int unsigned POP_W = $clog2(DATA_W + 1);
    localparam int unsigned EXT_W = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   bits_q, bits_d;
    logic               seen_q, seen_d;
    logic [LEN_W-1:0]   bcnt_q, bcnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               s1v_q, s1v_d;
    logic [POP_W-1:0]   s1pop_q, s1pop_d;

    logic [DATA_W-1:0]  diff_c;
    logic [POP_W-1:0]   pop_c;

    // Add with clamp at all-ones; the wide sum cannot overflow.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [EXT_W-1:0] s;
        s = EXT_W'(a) + EXT_W'(b);
        if (s > EXT_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return CNT_W'(s);
    endfunction

    // Number of mismatched bits in the current byte.
    always_comb begin
        diff_c = rx_data ^ ref_data;
        pop_c  = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            pop_c = pop_c + POP_W'(diff_c[i]);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bits_d  = bits_q;
        seen_d  = seen_q;
        bcnt_d  = bcnt_q;
        len_d   = len_q;
        s1v_d   = 1'b0;
        s1pop_d = s1pop_q;

        // Stage 2: fold the previous byte's popcount into the totals.
        if (s1v_q) begin
            err_d  = sat_add(err_q, s1pop_q);
            seen_d = seen_q | (s1pop_q != '0);
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (window_len == '0) ? ST_FLUSH : ST_RUN;
                    busy_d  = 1'b1;
                    err_d   = '0;
                    bits_d  = '0;
                    seen_d  = 1'b0;
                    bcnt_d  = '0;
                    len_d   = window_len;
                end
            end
            ST_RUN: begin
                if (rx_valid) begin
                    s1v_d   = 1'b1;
                    s1pop_d = pop_c;
                    bits_d  = sat_add(bits_q, POP_W'(DATA_W));
                    bcnt_d  = bcnt_q + LEN_W'(1);
                    if (bcnt_d == len_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            bits_q  <= '0;
            seen_q  <= 1'b0;
            bcnt_q  <= '0;
            len_q   <= '0;
            s1v_q   <= 1'b0;
            s1pop_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
            seen_q  <= seen_d;
            bcnt_q  <= bcnt_d;
            len_q   <= len_d;
            s1v_q   <= s1v_d;
            s1pop_q <= s1pop_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_count = err_q;
    assign bit_count = bits_q;
    assign err_seen  = seen_q;

endmodule

// File: tb/tb_ber_error_counter.sv
// Self-checking bench for ber_error_counter: a 32-bit instance and a 4-bit
// saturating instance share stimulus; expectations come from a byte-level model.
module tb_ber_error_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] window_len;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  ref_data;

    logic        busy, done, err_seen;
    logic [31:0] err_count, bit_count;
    logic        s_busy, s_done, s_seen;
    logic [3:0]  s_err, s_bits;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ber_error_counter #(.DATA_W(8), .CNT_W(32), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len),
        .rx_valid(rx_valid), .rx_data(rx_data), .ref_data(ref_data),
        .busy(busy), .done(done), .err_count(err_count),
        .bit_count(bit_count), .err_seen(err_seen)
    );

    ber_error_counter #(.DATA_W(8), .CNT_W(4), .LEN_W(16)) dut_s (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len),
        .rx_valid(rx_valid), .rx_data(rx_data), .ref_data(ref_data),
        .busy(s_busy), .done(s_done), .err_count(s_err),
        .bit_count(s_bits), .err_seen(s_seen)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Drives one window and models it: only the first len valid bytes presented
    // after the start count. lat = edges from the final acceptance edge (counted
    // as 1) up to the edge after which done is first seen; bad flags busy low
    // before done.
    task automatic run_window(input int len, input int pct, input int mode,
                              input bit do_start, input int inj,
                              output int e_err, output int e_bits,
                              output int lat, output bit bad);
        int acc;
        int k;
        bit v;
        logic [7:0] d;
        logic [7:0] r;
        acc = 0; k = -1; e_err = 0; e_bits = 0; lat = -1; bad = 1'b0;
        if (do_start) begin
            start = 1'b1; window_len = 16'(len);
            rx_valid = 1'b1; rx_data = 8'hFF; ref_data = 8'h00;
            tick();
            start = 1'b0;
        end
        if (len == 0) k = 1;
        for (int c = 0; c < 400 && lat < 0; c++) begin
            if (acc < len) v = ($urandom_range(99) < pct);
            else           v = 1'($urandom_range(1));
            case (mode)
                0: begin r = 8'hA5; d = 8'hA5; end
                1: begin r = 8'h00; d = 8'hFF; end
                3: begin r = 8'hA5; d = (acc == 2) ? 8'hA4 : 8'hA5; end
                default: begin
                    r = 8'($urandom);
                    d = r ^ (($urandom_range(2) == 0) ? 8'($urandom) : 8'h00);
                end
            endcase
            rx_valid = v; rx_data = d; ref_data = r;
            start = (c == inj);
            window_len = 16'd1;
            if (v && acc < len) begin
                acc++;
                e_err  += $countones(d ^ r);
                e_bits += 8;
                if (acc == len) k = 0;
            end
            tick();
            start = 1'b0;
            if (done) lat = k + 1;
            else begin
                if (!busy) bad = 1'b1;
                if (k >= 0) k++;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; window_len = '0;
        rx_valid = 1'b0; rx_data = '0; ref_data = '0;
        tick(); tick();
        checks++;
        if ({busy, done, err_seen} !== 3'b000 || err_count !== 32'd0 || bit_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b seen=%b err=%0d bits=%0d, want all zero",
                     busy, done, err_seen, err_count, bit_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        int ee, eb, lat; bit bad;
        run_window(4, 100, 0, 1'b1, -1, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || bad) begin
            errors++; $display("FAIL clean_latency: lat=%0d busy_drop=%b, want lat=2", lat, bad);
        end
        checks++;
        if (err_count !== 32'd0 || bit_count !== 32'd32 || err_seen !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_counts: err=%0d bits=%0d seen=%b busy=%b, want 0/32/0/0",
                     err_count, bit_count, err_seen, busy);
        end
        checks++;
        if (s_bits !== 4'd15) begin
            errors++; $display("FAIL clean_sat_bits: got %0d want 15", s_bits);
        end
        tick();
        checks++;
        if (done !== 1'b0 || bit_count !== 32'd32) begin
            errors++; $display("FAIL done_pulse_hold: done=%b bits=%0d, want 0/32", done, bit_count);
        end
    endtask

    task automatic test_single_bit();
        int ee, eb, lat; bit bad;
        run_window(4, 100, 3, 1'b1, -1, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || err_count !== 32'd1 || bit_count !== 32'd32 || err_seen !== 1'b1) begin
            errors++;
            $display("FAIL single_bit: lat=%0d err=%0d bits=%0d seen=%b, want 2/1/32/1",
                     lat, err_count, bit_count, err_seen);
        end
    endtask

    task automatic test_inversion_gaps();
        int ee, eb, lat; bit bad;
        run_window(3, 40, 1, 1'b1, -1, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || bad || err_count !== 32'd24 || bit_count !== 32'd24) begin
            errors++;
            $display("FAIL inversion_gaps: lat=%0d err=%0d bits=%0d, want 2/24/24",
                     lat, err_count, bit_count);
        end
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'hFF; ref_data = 8'h00;
            tick();
        end
        rx_valid = 1'b0;
        checks++;
        if (err_count !== 32'd24 || bit_count !== 32'd24 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_window: err=%0d bits=%0d done=%b, want 24/24/0",
                     err_count, bit_count, done);
        end
    endtask

    task automatic test_start_ignored();
        int ee, eb, lat; bit bad;
        run_window(6, 100, 2, 1'b1, 3, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || bad || err_count !== 32'(ee) || bit_count !== 32'(eb)) begin
            errors++;
            $display("FAIL start_in_run: lat=%0d err=%0d bits=%0d, want 2/%0d/%0d",
                     lat, err_count, bit_count, ee, eb);
        end
    endtask

    task automatic test_done_restart();
        int ee, eb, lat; bit bad;
        run_window(2, 100, 1, 1'b1, -1, ee, eb, lat, bad);
        start = 1'b1; window_len = 16'd5;
        tick();
        start = 1'b0;
        checks++;
        if (lat !== 2 || done !== 1'b0 || busy !== 1'b1 || err_count !== 32'd0 ||
            bit_count !== 32'd0 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL restart_on_done: lat=%0d done=%b busy=%b err=%0d bits=%0d seen=%b, want 2/0/1/0/0/0",
                     lat, done, busy, err_count, bit_count, err_seen);
        end
        run_window(5, 60, 2, 1'b0, -1, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || bad || err_count !== 32'(ee) || bit_count !== 32'(eb)) begin
            errors++;
            $display("FAIL restart_window: lat=%0d err=%0d bits=%0d, want 2/%0d/%0d",
                     lat, err_count, bit_count, ee, eb);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        start = 1'b1; window_len = 16'd8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rx_valid = 1'b1; rx_data = 8'hF0; ref_data = 8'h00;
            tick();
        end
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || err_count !== 32'd0 || bit_count !== 32'd0 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_window: busy=%b err=%0d bits=%0d seen=%b, want all zero",
                     busy, err_count, bit_count, err_seen);
        end
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            rx_valid = 1'b1; rx_data = 8'hFF; ref_data = 8'h00;
            tick();
            if (done || busy || bit_count != 32'd0) saw_done = 1'b1;
        end
        rx_valid = 1'b0;
        checks++;
        if (saw_done) begin
            errors++; $display("FAIL idle_after_reset: activity seen=%b, want 0", saw_done);
        end
    endtask

    task automatic test_zero_len();
        int ee, eb, lat; bit bad;
        run_window(0, 100, 1, 1'b1, -1, ee, eb, lat, bad);
        checks++;
        if (lat !== 2 || bad || err_count !== 32'd0 || bit_count !== 32'd0 || err_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: lat=%0d err=%0d bits=%0d seen=%b, want 2/0/0/0",
                     lat, err_count, bit_count, err_seen);
        end
    endtask

    task automatic test_saturation();
        int ee, eb, lat; bit bad;
        run_window(3, 100, 1, 1'b1, -1, ee, eb, lat, bad);
        checks++;
        if (s_done !== 1'b1 || s_err !== 4'd15 || s_bits !== 4'd15 || s_seen !== 1'b1) begin
            errors++;
            $display("FAIL saturation: done=%b err=%0d bits=%0d seen=%b, want 1/15/15/1",
                     s_done, s_err, s_bits, s_seen);
        end
    endtask

    task automatic test_random();
        int ee, eb, lat; bit bad; int len;
        for (int it = 0; it < 6; it++) begin
            len = int'($urandom_range(20, 1));
            run_window(len, 70, 2, 1'b1, -1, ee, eb, lat, bad);
            checks++;
            if (lat !== 2 || bad || err_count !== 32'(ee) || bit_count !== 32'(eb) ||
                err_seen !== (ee != 0) || s_err !== 4'(sat15(ee)) || s_bits !== 4'(sat15(eb))) begin
                errors++;
                $display("FAIL random_%0d: len=%0d lat=%0d err=%0d bits=%0d seen=%b s_err=%0d s_bits=%0d, want 2/%0d/%0d/%0d/%0d/%0d",
                         it, len, lat, err_count, bit_count, err_seen, s_err, s_bits,
                         ee, eb, (ee != 0), sat15(ee), sat15(eb));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single_bit();
        test_inversion_gaps();
        test_start_ignored();
        test_done_restart();
        test_reset_mid();
        test_zero_len();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
